// File: rtl/calc_unit_sequencer.sv
// calc_unit_sequencer: hands one command at a time to the divider, factorial
// or square-root unit, waits for its done (bounded by a timeout) and returns
// the result and status over a valid/ready response channel.
module calc_unit_sequencer #(
    parameter int unsigned W       = 28,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         abort,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic [1:0]   rsp_status,
    output logic         busy,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic         div_start,
    output logic         fct_start,
    output logic         sqr_start,
    input  logic         div_done,
    input  logic         fct_done,
    input  logic         sqr_done,
    input  logic [W-1:0] div_result,
    input  logic [W-1:0] fct_result,
    input  logic [W-1:0] sqr_result,
    input  logic         div_err,
    input  logic         fct_ovf,
    input  logic         sqr_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT);

    localparam logic [1:0] OpDiv     = 2'b00;
    localparam logic [1:0] OpFct     = 2'b01;
    localparam logic [1:0] OpSqr     = 2'b10;
    localparam logic [1:0] OpIllegal = 2'b11;

    localparam logic [1:0] StatOk      = 2'b00;
    localparam logic [1:0] StatUnitErr = 2'b01;
    localparam logic [1:0] StatTimeout = 2'b10;
    localparam logic [1:0] StatIllegal = 2'b11;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q;
    logic [1:0]      op_q;
    logic [CntW-1:0] cnt_q;

    logic            sel_done;
    logic [W-1:0]    sel_result;
    logic            sel_err;

    // Only commands can be taken in IDLE, and never while reset is held.
    assign cmd_ready = (state_q == StIdle) & ~rst;

    // Pick the done/result/error of the unit the latched op addresses.
    always_comb begin
        sel_done   = 1'b0;
        sel_result = '0;
        sel_err    = 1'b0;
        unique case (op_q)
            OpDiv: begin
                sel_done   = div_done;
                sel_result = div_result;
                sel_err    = div_err;
            end
            OpFct: begin
                sel_done   = fct_done;
                sel_result = fct_result;
                sel_err    = fct_ovf;
            end
            OpSqr: begin
                sel_done   = sqr_done;
                sel_result = sqr_result;
                sel_err    = sqr_err;
            end
            default: begin
                sel_done   = 1'b0;
                sel_result = '0;
                sel_err    = 1'b0;
            end
        endcase
    end

    // Sequencer FSM; every output except cmd_ready is a register written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= OpDiv;
            cnt_q      <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= StatOk;
            busy       <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            div_start  <= 1'b0;
            fct_start  <= 1'b0;
            sqr_start  <= 1'b0;
        end else if (abort) begin
            // Cancel: starts set on this edge would be due next cycle, so
            // clearing them here also suppresses a pending pulse.
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            div_start <= 1'b0;
            fct_start <= 1'b0;
            sqr_start <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q <= cmd_op;
                        op_a <= cmd_a;
                        op_b <= cmd_b;
                        busy <= 1'b1;
                        if (cmd_op == OpIllegal) begin
                            state_q    <= StResp;
                            rsp_valid  <= 1'b1;
                            rsp_data   <= '0;
                            rsp_status <= StatIllegal;
                        end else begin
                            // Start goes high for exactly the ISSUE cycle.
                            state_q   <= StIssue;
                            div_start <= (cmd_op == OpDiv);
                            fct_start <= (cmd_op == OpFct);
                            sqr_start <= (cmd_op == OpSqr);
                        end
                    end
                end
                StIssue: begin
                    div_start <= 1'b0;
                    fct_start <= 1'b0;
                    sqr_start <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= StWait;
                end
                StWait: begin
                    // Done is checked first so it wins over a same-cycle timeout.
                    if (sel_done) begin
                        state_q    <= StResp;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= sel_result;
                        rsp_status <= sel_err ? StatUnitErr : StatOk;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        state_q    <= StResp;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= '1;
                        rsp_status <= StatTimeout;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_unit_sequencer.sv
// Bench for calc_unit_sequencer: directed scenarios plus randomized commands,
// with the bench acting as all three arithmetic units.
module tb_calc_unit_sequencer;

    localparam int unsigned W       = 28;
    localparam int unsigned TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         rst, abort, cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [1:0]   cmd_op, rsp_status;
    logic [W-1:0] cmd_a, cmd_b, rsp_data, op_a, op_b;
    logic         div_start, fct_start, sqr_start;
    logic         div_done, fct_done, sqr_done;
    logic [W-1:0] div_result, fct_result, sqr_result;
    logic         div_err, fct_ovf, sqr_err;

    int checks = 0;
    int errors = 0;

    calc_unit_sequencer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .busy(busy), .op_a(op_a), .op_b(op_b),
        .div_start(div_start), .fct_start(fct_start), .sqr_start(sqr_start),
        .div_done(div_done), .fct_done(fct_done), .sqr_done(sqr_done),
        .div_result(div_result), .fct_result(fct_result), .sqr_result(sqr_result),
        .div_err(div_err), .fct_ovf(fct_ovf), .sqr_err(sqr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // What an ideal arithmetic unit would return.
    function automatic void unit_model(input logic [1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       output logic [W-1:0] res, output logic err);
        longint acc, r, t;
        longint maxv = (longint'(1) << W) - 1;
        res = '0;
        err = 1'b0;
        case (op)
            2'd0: begin
                if (b == 0) begin res = '1; err = 1'b1; end
                else res = a / b;
            end
            2'd1: begin
                acc = 1;
                for (int i = 2; i <= int'(a) && !err; i++) begin
                    acc = acc * i;
                    if (acc > maxv) err = 1'b1;
                end
                res = W'(acc);
            end
            2'd2: begin
                r = 0;
                for (int i = 13; i >= 0; i--) begin
                    t = r | (longint'(1) << i);
                    if (t * t <= longint'(a)) r = t;
                end
                res = W'(r);
            end
            default: res = '0;
        endcase
    endfunction

    // Expected response: d = cycles from the start pulse to the unit's done.
    function automatic void rsp_model(input logic [1:0] op, input int d,
                                      input logic [W-1:0] res, input logic err,
                                      output int lat, output logic [W-1:0] data,
                                      output logic [1:0] st);
        if (op == 2'd3) begin
            lat = 1; data = '0; st = 2'd3;
        end else if (d <= int'(TIMEOUT)) begin
            lat = 2 + d; data = res; st = err ? 2'd1 : 2'd0;
        end else begin
            lat = 2 + int'(TIMEOUT); data = '1; st = 2'd2;
        end
    endfunction

    // Issue one command, play the units, check the response, then either
    // complete the handshake after bp stalled cycles or pulse rst in RESP.
    task automatic run_cmd(input string name, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input int d, input logic [W-1:0] res, input logic err,
                           input int bp, input bit rst_mode);
        int           lat, cyc, scnt, scyc;
        logic [2:0]   svec;
        logic [W-1:0] edata;
        logic [1:0]   est;
        bit           got;
        rsp_model(op, d, res, err, lat, edata, est);
        check({name, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check({name, ".op_a"}, 32'(op_a), 32'(a));
        check({name, ".op_b"}, 32'(op_b), 32'(b));
        cyc = 1; got = 1'b0; scnt = 0; scyc = 0; svec = '0;
        while (!got && cyc <= int'(TIMEOUT) + 6) begin
            if (div_start | fct_start | sqr_start) begin
                scnt += int'(div_start) + int'(fct_start) + int'(sqr_start);
                svec |= {sqr_start, fct_start, div_start};
                if (scyc == 0) scyc = cyc;
            end
            if (rsp_valid) begin
                got = 1'b1;
                check({name, ".latency"}, 32'(cyc), 32'(lat));
            end else begin
                if (op != 2'd3 && cyc == 3) begin
                    // Stray done from an unselected unit.
                    if (op == 2'd0) begin fct_done = 1'b1; fct_result = 3; end
                    else begin div_done = 1'b1; div_result = 3; end
                end
                if (op != 2'd3 && cyc == 1 + d) begin
                    case (op)
                        2'd0: begin div_done = 1'b1; div_result = res; div_err = err; end
                        2'd1: begin fct_done = 1'b1; fct_result = res; fct_ovf = err; end
                        default: begin sqr_done = 1'b1; sqr_result = res; sqr_err = err; end
                    endcase
                end
                @(posedge clk); #1;
                div_done = 1'b0; fct_done = 1'b0; sqr_done = 1'b0;
                cyc++;
            end
        end
        if (!got) check({name, ".rsp_valid_seen"}, 32'd0, 32'd1);
        check({name, ".start_count"}, 32'(scnt), (op != 2'd3) ? 32'd1 : 32'd0);
        check({name, ".start_which"}, 32'(svec), (op != 2'd3) ? 32'(3'b001 << op) : 32'd0);
        check({name, ".start_cycle"}, 32'(scyc), (op != 2'd3) ? 32'd1 : 32'd0);
        check({name, ".rsp_data"}, 32'(rsp_data), 32'(edata));
        check({name, ".rsp_status"}, 32'(rsp_status), 32'(est));
        for (int i = 0; i < bp; i++) begin
            cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = ~a; cmd_b = ~b;
            @(posedge clk); #1;
            check({name, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            check({name, ".hold_data"}, 32'(rsp_data), 32'(edata));
            check({name, ".hold_status"}, 32'(rsp_status), 32'(est));
            check({name, ".hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
            check({name, ".hold_op_a"}, 32'(op_a), 32'(a));
        end
        cmd_valid = 1'b0;
        if (rst_mode) begin
            rst = 1'b1;
            #1;
            check({name, ".rst_cmd_ready"}, 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            check({name, ".rst_valid"}, 32'(rsp_valid), 32'd0);
            check({name, ".rst_data"}, 32'(rsp_data), 32'd0);
            check({name, ".rst_status"}, 32'(rsp_status), 32'd0);
            check({name, ".rst_busy"}, 32'(busy), 32'd0);
            check({name, ".rst_op_a"}, 32'(op_a), 32'd0);
            check({name, ".rst_op_b"}, 32'(op_b), 32'd0);
            check({name, ".rst_starts"}, 32'({div_start, fct_start, sqr_start}), 32'd0);
            #1;
            check({name, ".rst_release_ready"}, 32'(cmd_ready), 32'd1);
        end else begin
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            check({name, ".post_valid"}, 32'(rsp_valid), 32'd0);
            check({name, ".post_busy"}, 32'(busy), 32'd0);
            check({name, ".post_cmd_ready"}, 32'(cmd_ready), 32'd1);
            check({name, ".post_op_a"}, 32'(op_a), 32'(a));
        end
    endtask

    initial begin
        logic [1:0]   op;
        logic [W-1:0] a, b, res;
        logic         err;
        int           d;

        rst = 1'b1; abort = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b0;
        div_done = 1'b0; fct_done = 1'b0; sqr_done = 1'b0;
        div_result = '0; fct_result = '0; sqr_result = '0;
        div_err = 1'b0; fct_ovf = 1'b0; sqr_err = 1'b0;

        @(posedge clk); #1;
        check("reset.cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset.rsp_data", 32'(rsp_data), 32'd0);
        check("reset.rsp_status", 32'(rsp_status), 32'd0);
        check("reset.op_a", 32'(op_a), 32'd0);
        check("reset.starts", 32'({div_start, fct_start, sqr_start}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;

        run_cmd("div100_7", 2'd0, 100, 7, 5, 14, 1'b0, 0, 1'b0);
        run_cmd("sqrt81_bp", 2'd2, 81, 0, 3, 9, 1'b0, 3, 1'b0);
        run_cmd("illegal", 2'd3, 5, 0, 1, 0, 1'b0, 0, 1'b0);
        run_cmd("fct_timeout", 2'd1, 20, 0, 100, 0, 1'b0, 0, 1'b0);
        run_cmd("fct_last_done", 2'd1, 20, 0, int'(TIMEOUT), 0, 1'b1, 0, 1'b0);

        // Abort in the second WAIT cycle, then a late done while idle.
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 50; cmd_b = 5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("abort.div_start", 32'(div_start), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort.cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        div_done = 1'b1; div_result = 10;
        @(posedge clk); #1;
        div_done = 1'b0;
        check("abort.late_valid", 32'(rsp_valid), 32'd0);
        check("abort.late_busy", 32'(busy), 32'd0);
        run_cmd("sqrt16_after_abort", 2'd2, 16, 0, 2, 4, 1'b0, 0, 1'b0);

        run_cmd("rst_in_resp", 2'd2, 49, 33, 2, 7, 1'b0, 0, 1'b1);

        for (int n = 0; n < 24; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 5000));
            if (op == 2'd1) a = W'($urandom_range(0, 14));
            d  = $urandom_range(1, TIMEOUT + 3);
            unit_model(op, a, b, res, err);
            run_cmd($sformatf("rand%0d", n), op, a, b, d, res, err,
                    $urandom_range(0, 2), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_unit_sequencer.md
# calc_unit_sequencer

Sequencer between the calculator FSM and the shared multi-cycle arithmetic units: divider, factorial and square root. It accepts one command at a time over a valid/ready handshake and latches the operands. It then fires a single-cycle start pulse at the selected unit, waits for that unit's done with a timeout, and returns the result and status over a second valid/ready handshake. Only one unit is active at any time. An escape/abort input cancels the operation in flight.

## Interface
- `W`, 28: operand and result width.
- `TIMEOUT`, 1024: maximum number of WAIT cycles before a timeout is declared (≥2).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `abort` in 1: cancel the current operation (escape key).
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_op` in 2: 00 divide, 01 factorial, 10 square root, 11 illegal.
- `cmd_a`, `cmd_b` in W: operands; `cmd_b` is used by divide only.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_data` out W: result.
- `rsp_status` out 2: 00 ok, 01 unit error/overflow, 10 timeout, 11 illegal op.
- `busy` out 1: high in every state except IDLE.
- `op_a`, `op_b` out W: latched operands driven to all units.
- `div_start`, `fct_start`, `sqr_start` out 1: one-cycle start pulses.
- `div_done`, `fct_done`, `sqr_done` in 1: unit completion strobes.
- `div_result`, `fct_result`, `sqr_result` in W: unit results, valid when the matching done is high.
- `div_err`, `fct_ovf`, `sqr_err` in 1: unit error flags, sampled together with the matching done.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered except `cmd_ready`, which is `(state==IDLE) & ~rst`.
- IDLE
  - `cmd_ready` is high.
  - On `cmd_valid & cmd_ready`, latch `cmd_op`, `cmd_a` and `cmd_b` into `op_a`/`op_b`.
  - If op = 11, go to RESP with data 0 and status 11; no start pulse is issued.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle)
  - Exactly one start line is high, selected by the latched op; the other two stay low.
  - Clear the timeout counter, then go to WAIT.
- WAIT
  - Only the selected unit's done is observed; done strobes from the other two units are ignored.
  - On the selected done, capture its result into `rsp_data`. Status is 01 if that unit's error flag is high, else 00. Go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without done, go to RESP with data all-ones and status 10.
  - If done and timeout occur in the same cycle, done wins.
- RESP
  - `rsp_valid` is high, and `rsp_data`/`rsp_status` are held stable until `rsp_valid & rsp_ready`; then go to IDLE.
  - No new command is accepted until the state is back in IDLE.
- `op_a`/`op_b` hold their latched values from the accept edge until the next accept; operand width is W with no truncation.
- `abort` has the highest priority. From any state, the next state is IDLE; `rsp_valid`, all start pulses and `busy` are forced low in the following cycle. Any start pulse due in the abort cycle is suppressed. A late done from the aborted unit arriving while in IDLE is ignored.
- Reset values: state IDLE, `rsp_valid`=0, `rsp_data`=0, `rsp_status`=00, all starts 0, `busy`=0, `op_a`=`op_b`=0, counter 0. `cmd_ready`=0 while `rst` is high.

## Timing
- Accept edge E (cycle 0). ISSUE is cycle 1, with the start pulse high for exactly cycle 1. WAIT begins in cycle 2.
- Done observed in cycle N produces `rsp_valid` in cycle N+1. With no backpressure, `cmd_ready` returns one cycle after the `rsp_ready` handshake edge.
- Illegal op: `rsp_valid` in cycle 1.
- Timeout: `rsp_valid` appears TIMEOUT cycles after WAIT entry.
- Minimum command-to-command spacing: 4 cycles (accept, ISSUE, WAIT with done in its first cycle, RESP handshake).
- `rst` asserted mid-operation behaves the same as `abort` and additionally restores all reset values at the next edge.

## Test plan
- Divide, a=100, b=7. `div_done` arrives 5 cycles after `div_start` with result 14 and err=0. Required: `div_start` is high for exactly 1 cycle, `fct_start`/`sqr_start` stay 0, and the response is data 14, status 00, one cycle after done.
- Square root, a=81. Done returns 9. Hold `rsp_ready` low for 3 cycles. Required: data 9 and status 00 remain stable, `cmd_ready` stays 0, and a `cmd_valid` presented meanwhile is not accepted.
- `cmd_op`=11, a=5. Required: no start pulse, and `rsp_valid` in cycle 1 with data 0 and status 11.
- TIMEOUT=8, factorial a=20, no `fct_done` ever. Pulse `div_done` with result 3 in WAIT, which must be ignored. Required: after 8 WAIT cycles, data 0xFFFFFFF and status 10. A second run with `fct_done` (result 0, ovf=1) landing in the final WAIT cycle must give status 01.
- Divide issued, then `abort` in the second WAIT cycle, with `div_done` arriving 2 cycles later. Required: back in IDLE with no `rsp_valid` and the late done ignored. A subsequent sqrt a=16 must return 4 with status 00.
- `rst` pulsed for 1 cycle while in RESP. Required: all outputs at their reset values the next cycle, and `cmd_ready`=1 the cycle after `rst` is released.
